// File: rtl/mini_intc_pkg.sv
// Shared constants for the mini_intc interrupt collector.
package mini_intc_pkg;
  localparam int MINI_INTC_MAX_SRC = 16;
  localparam int MISS_CNT_W = 8;
  localparam logic [MISS_CNT_W-1:0] MISS_CNT_MAX = 8'hFF;
endpackage

// File: rtl/mini_intc_prio_enc.sv
// Lowest-index-first priority encoder; idx is 0 when nothing is requested.
module mini_intc_prio_enc
  import mini_intc_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W = 2
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               any,
  output logic [ID_W-1:0]    idx
);
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end
endmodule

// File: rtl/mini_intc.sv
// Interrupt collector: sticky pending, mask, overflow, valid/ack presentation.
// Optional per-source miss counters enabled by MINI_INTC_MISS_COUNT_EN.
module mini_intc
  import mini_intc_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     src_pulse,
  input  logic                   mask_we,
  input  logic [NUM_SRC-1:0]     mask_wdata,
  input  logic                   ovf_clr,
  output logic                   irq_valid,
  output logic [ID_W-1:0]        irq_id,
  input  logic                   irq_ack,
  output logic [NUM_SRC-1:0]     pending,
  output logic [NUM_SRC-1:0]     mask,
  output logic [NUM_SRC-1:0]     overflow,
  output logic [8*NUM_SRC-1:0]   miss_count
);
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] overflow_q, overflow_d;
  logic [NUM_SRC-1:0] acc_vec;
  logic [NUM_SRC-1:0] ovf_ev;
  logic               accept;

  mini_intc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_enc (
    .req (pending_q & ~mask_q),
    .any (irq_valid),
    .idx (irq_id)
  );

  assign accept = irq_valid & irq_ack;

  always_comb begin
    acc_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      acc_vec[i] = accept && (irq_id == ID_W'(i));
    end
    // a pulse coinciding with its own accept re-arms rather than overflows
    ovf_ev     = src_pulse & pending_q & ~acc_vec;
    pending_d  = (pending_q & ~acc_vec) | src_pulse;
    overflow_d = ovf_clr ? ovf_ev : (overflow_q | ovf_ev);
    mask_d     = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      mask_q     <= '1;
      overflow_q <= '0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending  = pending_q;
  assign mask     = mask_q;
  assign overflow = overflow_q;

`ifdef MINI_INTC_MISS_COUNT_EN
  logic [MISS_CNT_W-1:0] cnt_q [NUM_SRC];
  logic [MISS_CNT_W-1:0] cnt_d [NUM_SRC];

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ovf_clr) begin
        cnt_d[i] = ovf_ev[i] ? MISS_CNT_W'(1) : '0;
      end else if (ovf_ev[i] && cnt_q[i] != MISS_CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + MISS_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst) cnt_q[i] <= '0;
      else     cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
    assign miss_count[8*g +: 8] = cnt_q[g];
  end
`else
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_mini_intc.sv
// Randomized and directed bench for mini_intc against an array-level model.
module tb_mini_intc;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_pulse;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        ovf_clr;
  logic        irq_valid;
  logic [1:0]  irq_id;
  logic        irq_ack;
  logic [3:0]  pending;
  logic [3:0]  mask;
  logic [3:0]  overflow;
  logic [31:0] miss_count;

  int passed = 0;
  int total = 0;

  bit m_pend [4];
  bit m_mask [4];
  bit m_ovf  [4];
  int m_cnt  [4];

  mini_intc #(.NUM_SRC(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_pulse  (src_pulse),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ovf_clr    (ovf_clr),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .pending    (pending),
    .mask       (mask),
    .overflow   (overflow),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int model_id();
    for (int i = 0; i < 4; i++) if (m_pend[i] && !m_mask[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] pack(input bit v [4]);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic check_all(input string tag);
    int id;
    logic [31:0] mc;
    id = model_id();
    mc = '0;
`ifdef MINI_INTC_MISS_COUNT_EN
    for (int i = 0; i < 4; i++) mc[8*i +: 8] = 8'(m_cnt[i]);
`endif
    check({tag, ".valid"}, 32'(irq_valid), 32'(id >= 0));
    check({tag, ".id"}, 32'(irq_id), (id >= 0) ? 32'(id) : 32'd0);
    check({tag, ".pend"}, 32'(pending), 32'(pack(m_pend)));
    check({tag, ".mask"}, 32'(mask), 32'(pack(m_mask)));
    check({tag, ".ovf"}, 32'(overflow), 32'(pack(m_ovf)));
    check({tag, ".miss"}, miss_count, mc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0; m_mask[i] = 1; m_ovf[i] = 0; m_cnt[i] = 0;
    end
  endtask

  // one clock: drive at negedge, update model, check at next negedge
  task automatic cyc(input string tag, input logic [3:0] p, input bit mwe,
                     input logic [3:0] mwd, input bit oc, input bit ak);
    int id;
    bit acc, ev;
    src_pulse = p; mask_we = mwe; mask_wdata = mwd;
    ovf_clr = oc; irq_ack = ak;
    id = model_id();
    for (int i = 0; i < 4; i++) begin
      acc = ak && (id == i);
      ev = p[i] && m_pend[i] && !acc;
      m_pend[i] = (m_pend[i] && !acc) || p[i];
      m_ovf[i] = oc ? ev : (m_ovf[i] || ev);
      if (oc) m_cnt[i] = ev ? 1 : 0;
      else if (ev && m_cnt[i] < 255) m_cnt[i]++;
      if (mwe) m_mask[i] = mwd[i];
    end
    @(posedge clk);
    @(negedge clk);
    src_pulse = '0; mask_we = 0; ovf_clr = 0; irq_ack = 0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    check_all(tag);
  endtask

  initial begin
    rst = 1; src_pulse = '0; mask_we = 0; mask_wdata = '0;
    ovf_clr = 0; irq_ack = 0;
    model_reset();
    @(negedge clk);
    do_reset("reset");
    check("k_reset_mask", 32'(mask), 32'hF);

    // basic capture and ack
    cyc("t1_unmask", 4'b0000, 1, 4'b0000, 0, 0);
    cyc("t1_pulse", 4'b0100, 0, 0, 0, 0);
    check("k_t1_id", 32'(irq_id), 32'd2);
    cyc("t1_ack", 4'b0000, 0, 0, 0, 1);
    check("k_t1_valid", 32'(irq_valid), 32'd0);

    // priority order
    cyc("t2_pulse", 4'b1010, 0, 0, 0, 0);
    cyc("t2_ack1", 4'b0000, 0, 0, 0, 1);
    check("k_t2_id3", 32'(irq_id), 32'd3);
    cyc("t2_ack3", 4'b0000, 0, 0, 0, 1);

    // masked capture, then unmask
    cyc("t3_mask", 4'b0000, 1, 4'b0001, 0, 0);
    cyc("t3_pulse", 4'b0001, 0, 0, 0, 0);
    cyc("t3_unmask", 4'b0000, 1, 4'b0000, 0, 0);
    check("k_t3_valid", 32'(irq_valid), 32'd1);

    // overflow and clear
    for (int k = 0; k < 3; k++) cyc("t4_ovf", 4'b0001, 0, 0, 0, 0);
    check("k_t4_ovf", 32'(overflow), 32'h1);
    cyc("t4_clr", 4'b0000, 0, 0, 1, 0);

    // ack coinciding with new pulse
    cyc("t5_same", 4'b0001, 0, 0, 0, 1);
    check("k_t5_pend", 32'(pending[0]), 32'd1);
    cyc("t5_drain", 4'b0000, 0, 0, 0, 1);

    // saturation, then reset mid-sequence
    for (int k = 0; k < 300; k++) cyc("t6_sat", 4'b0010, 0, 0, 0, 0);
    cyc("t6_ack_mask", 4'b0000, 1, 4'b1111, 0, 1);
    do_reset("t6_rst");
    check("k_t6_miss", miss_count, 32'd0);

    // randomized traffic including simultaneous clear/event and ack/mask
    for (int k = 0; k < 600; k++) begin
      cyc("rnd", 4'($urandom) & 4'($urandom), $urandom_range(0, 9) == 0,
          4'($urandom), $urandom_range(0, 15) == 0, 1'($urandom));
      if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
